maze_render_pipe: RTL and testbench

//  Pipelined, parametrised maze pixel renderer between the VGA timing generator and the RGB output regs.

---
 rtl/maze_render_pipe.sv | 198 +++++++++++++++++++
 tb/tb_maze_render_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_render_pipe.sv
// Maze pixel renderer: raster-tracked tile counters, external wall ROM lookup,
// blinking exit tile and player sprite, with level/player/blink snapshotted at frame start.
module maze_render_pipe #(
  parameter int TILE_W       = 40,
  parameter int TILE_H       = 40,
  parameter int NUM_COLS     = 16,
  parameter int NUM_ROWS     = 12,
  parameter int WALL_MARGIN  = 4,
  parameter int BLK_SIZE     = 10,
  parameter int COLOR_W      = 4,
  parameter int EXIT_COL     = 15,
  parameter int EXIT_ROW     = 11,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_valid,
  input  logic [10:0]        curr_x,
  input  logic [10:0]        curr_y,
  input  logic [10:0]        blkpos_x,
  input  logic [10:0]        blkpos_y,
  input  logic [1:0]         level_select,
  output logic [1:0]         maze_level,
  output logic [4:0]         maze_row,
  output logic [4:0]         maze_col,
  input  logic [3:0]         walls,
  output logic [COLOR_W-1:0] draw_r,
  output logic [COLOR_W-1:0] draw_g,
  output logic [COLOR_W-1:0] draw_b,
  output logic               draw_valid,
  output logic               sync_err
);

  localparam int XT_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int YT_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int BC_W = $clog2(BLINK_FRAMES) + 1;
  localparam logic [XT_W-1:0]    XT_LAST = XT_W'(TILE_W - 1);
  localparam logic [YT_W-1:0]    YT_LAST = YT_W'(TILE_H - 1);
  localparam logic [COLOR_W-1:0] CMAX    = '1;

  // frame-start snapshot
  logic        fs;
  logic        armed;
  logic [1:0]  level_q;
  logic [10:0] bx_q, by_q;
  logic [BC_W-1:0] blink_cnt;
  logic        blink_on, blink_q;

  assign fs = pix_valid && (curr_x == 11'd0) && (curr_y == 11'd0);

  // blink_q holds the phase in force before this frame's advance, so the
  // first BLINK_FRAMES frames after reset show the exit lit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed     <= 1'b0;
      level_q   <= 2'd0;
      bx_q      <= 11'd0;
      by_q      <= 11'd0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      blink_q   <= 1'b1;
    end else if (fs) begin
      armed   <= 1'b1;
      level_q <= level_select;
      bx_q    <= blkpos_x;
      by_q    <= blkpos_y;
      blink_q <= blink_on;
      if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // S1: raster-tracked tile counters
  logic [XT_W-1:0] xt, xt_step;
  logic [YT_W-1:0] yt, yt_step;
  logic [4:0]      col, col_step, row, row_step;
  logic [10:0]     prev_x, prev_y, x1, y1;
  logic            v1, raster_err;

  always_comb begin
    xt_step  = (xt == XT_LAST) ? '0 : xt + 1'b1;
    col_step = ((xt == XT_LAST) && (col != 5'd31)) ? col + 5'd1 : col;
    yt_step  = (yt == YT_LAST) ? '0 : yt + 1'b1;
    row_step = ((yt == YT_LAST) && (row != 5'd31)) ? row + 5'd1 : row;
    if (curr_x != 11'd0)
      raster_err = (curr_x != prev_x + 11'd1);
    else
      raster_err = (curr_y != 11'd0) && (curr_y != prev_y + 11'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xt <= '0; yt <= '0; col <= 5'd0; row <= 5'd0;
      prev_x <= 11'd0; prev_y <= 11'd0;
      x1 <= 11'd0; y1 <= 11'd0;
      v1 <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      v1 <= pix_valid && (armed || fs);
      x1 <= curr_x;
      y1 <= curr_y;
      if (fs)
        sync_err <= 1'b0;
      else if (pix_valid && raster_err)
        sync_err <= 1'b1;
      if (pix_valid) begin
        prev_x <= curr_x;
        prev_y <= curr_y;
        if (curr_x == 11'd0) begin
          xt  <= '0;
          col <= 5'd0;
          if (curr_y == 11'd0) begin
            yt  <= '0;
            row <= 5'd0;
          end else begin
            yt  <= yt_step;
            row <= row_step;
          end
        end else begin
          xt  <= xt_step;
          col <= col_step;
        end
      end
    end
  end

  assign maze_row   = row;
  assign maze_col   = col;
  assign maze_level = level_q;

  // S2: context aligned with the ROM data returned for the S1 address
  logic [XT_W-1:0] xt2;
  logic [YT_W-1:0] yt2;
  logic [4:0]      col2, row2;
  logic [10:0]     x2, y2;
  logic            v2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xt2 <= '0; yt2 <= '0; col2 <= 5'd0; row2 <= 5'd0;
      x2 <= 11'd0; y2 <= 11'd0; v2 <= 1'b0;
    end else begin
      xt2 <= xt; yt2 <= yt; col2 <= col; row2 <= row;
      x2 <= x1; y2 <= y1; v2 <= v1;
    end
  end

  logic in_maze, on_player, on_wall, on_exit;
  logic [11:0] bx_end, by_end;
  logic [COLOR_W-1:0] r_c, g_c, b_c;

  always_comb begin
    bx_end    = {1'b0, bx_q} + 12'(BLK_SIZE);
    by_end    = {1'b0, by_q} + 12'(BLK_SIZE);
    on_player = (x2 >= bx_q) && ({1'b0, x2} < bx_end) &&
                (y2 >= by_q) && ({1'b0, y2} < by_end);
    in_maze   = (col2 < 5'(NUM_COLS)) && (row2 < 5'(NUM_ROWS));
    on_wall   = in_maze && (level_q != 2'd3) &&
                ((walls[3] && (yt2 <  YT_W'(WALL_MARGIN))) ||
                 (walls[2] && (yt2 >= YT_W'(TILE_H - WALL_MARGIN))) ||
                 (walls[1] && (xt2 <  XT_W'(WALL_MARGIN))) ||
                 (walls[0] && (xt2 >= XT_W'(TILE_W - WALL_MARGIN))));
    on_exit   = blink_q && (row2 == 5'(EXIT_ROW)) && (col2 == 5'(EXIT_COL)) &&
                (xt2 >= XT_W'(WALL_MARGIN)) && (xt2 < XT_W'(TILE_W - WALL_MARGIN)) &&
                (yt2 >= YT_W'(WALL_MARGIN)) && (yt2 < YT_W'(TILE_H - WALL_MARGIN));
    r_c = '0;
    g_c = '0;
    b_c = '0;
    if (on_player) begin
      g_c = CMAX;
    end else if (on_wall) begin
      r_c = CMAX;
    end else if (on_exit) begin
      r_c = CMAX;
      g_c = CMAX;
    end else if (in_maze) begin
      b_c = CMAX;
    end
  end

  // S3: registered colour, forced black when not valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      draw_valid <= 1'b0;
      draw_r <= '0; draw_g <= '0; draw_b <= '0;
    end else begin
      draw_valid <= v2;
      draw_r <= v2 ? r_c : '0;
      draw_g <= v2 ? g_c : '0;
      draw_b <= v2 ? b_c : '0;
    end
  end

endmodule

// File: tb/tb_maze_render_pipe.sv
// Directed raster bench for maze_render_pipe: small geometry, ROM model,
// per-cycle comparison against a coordinate-level reference plus literal pixel probes.
module tb_maze_render_pipe;

  localparam int TW = 8, TH = 8, NC = 4, NR = 3, WM = 2, BLK = 3, CW = 4;
  localparam int EC = 3, ER = 2, BF = 2;
  localparam int RW = 40, RH = 28, HBL = 4, VBL = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          pix_valid;
  logic [10:0]   curr_x, curr_y, blkpos_x, blkpos_y;
  logic [1:0]    level_select;
  logic [1:0]    maze_level;
  logic [4:0]    maze_row, maze_col;
  logic [3:0]    walls;
  logic [CW-1:0] draw_r, draw_g, draw_b;
  logic          draw_valid, sync_err;

  maze_render_pipe #(
    .TILE_W(TW), .TILE_H(TH), .NUM_COLS(NC), .NUM_ROWS(NR), .WALL_MARGIN(WM),
    .BLK_SIZE(BLK), .COLOR_W(CW), .EXIT_COL(EC), .EXIT_ROW(ER), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .curr_x(curr_x), .curr_y(curr_y),
    .blkpos_x(blkpos_x), .blkpos_y(blkpos_y), .level_select(level_select),
    .maze_level(maze_level), .maze_row(maze_row), .maze_col(maze_col), .walls(walls),
    .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b),
    .draw_valid(draw_valid), .sync_err(sync_err)
  );

  // level ROM contents {top,bottom,left,right}
  function automatic logic [3:0] rom_walls(input int l, input int r, input int c);
    logic [3:0] w;
    w = 4'b0000;
    if (r >= NR || c >= NC) return 4'b0000;
    if (l == 0) begin
      if (r == 0) w[3] = 1'b1;
      if (c == 0) w[1] = 1'b1;
      if (r == 1 && c == 1) w = 4'b0001;
    end else if (l == 1) begin
      if (r == 1) w[2] = 1'b1;
      if (r == 0 && c == 0) w[3] = 1'b1;
    end else if (l == 2) begin
      if (r == 1 && c == 2) w = 4'b0101;
    end else begin
      w = 4'b1111;
    end
    return w;
  endfunction

  always @(posedge clk) walls <= rom_walls(int'(maze_level), int'(maze_row), int'(maze_col));

  // reference model state
  int   n_cmp = 0, n_bad = 0;
  bit   checking = 0;
  bit   armed_m, sync_m, blink_m, lat_pending;
  int   prev_x_m, prev_y_m, ex_m, ey_m, lvl_m, bx_m, by_m, fs_cnt;
  int   row_m, col_m;
  int   frame_no = -1;
  longint fs_time;
  bit   hv[3], hpv[3];
  logic [11:0] hrgb[3];
  int   hf[3], hx[3], hy[3];

  typedef struct { int f; int x; int y; logic [11:0] rgb; } probe_t;
  probe_t probes[$];

  task automatic model_update();
    bit fs, pl, ins, wl, ext;
    int xt, yt, x, y;
    logic [3:0] w;
    logic [11:0] rgb;
    for (int i = 2; i > 0; i--) begin
      hv[i] = hv[i-1]; hpv[i] = hpv[i-1]; hrgb[i] = hrgb[i-1];
      hf[i] = hf[i-1]; hx[i] = hx[i-1]; hy[i] = hy[i-1];
    end
    if (!rst) begin
      armed_m = 0; sync_m = 0; blink_m = 1; lat_pending = 0;
      prev_x_m = 0; prev_y_m = 0; ex_m = 0; ey_m = 0;
      lvl_m = 0; bx_m = 0; by_m = 0; fs_cnt = 0; row_m = 0; col_m = 0;
      for (int i = 0; i < 3; i++) begin hv[i] = 0; hpv[i] = 0; hrgb[i] = 12'h000; end
      return;
    end
    x  = int'(curr_x);
    y  = int'(curr_y);
    fs = pix_valid && x == 0 && y == 0;
    if (fs) begin
      if (!armed_m) begin lat_pending = 1; fs_time = longint'($time) - 1; end
      lvl_m = int'(level_select); bx_m = int'(blkpos_x); by_m = int'(blkpos_y);
      blink_m = ((fs_cnt / BF) % 2) == 0;
      fs_cnt++; frame_no++;
      armed_m = 1; sync_m = 0;
    end
    if (pix_valid) begin
      if (x == 0) begin
        ex_m = 0;
        if (y == 0) ey_m = 0;
        else begin
          if (y != prev_y_m + 1) sync_m = 1;
          ey_m++;
        end
      end else begin
        if (x != prev_x_m + 1) sync_m = 1;
        ex_m++;
      end
      prev_x_m = x; prev_y_m = y;
    end
    col_m = (ex_m / TW > 31) ? 31 : ex_m / TW;
    row_m = (ey_m / TH > 31) ? 31 : ey_m / TH;
    xt = ex_m % TW;
    yt = ey_m % TH;
    ins = col_m < NC && row_m < NR;
    w   = rom_walls(lvl_m, row_m, col_m);
    wl  = ins && lvl_m != 3 && ((w[3] && yt < WM) || (w[2] && yt >= TH - WM) ||
                                (w[1] && xt < WM) || (w[0] && xt >= TW - WM));
    ext = blink_m && row_m == ER && col_m == EC &&
          xt >= WM && xt < TW - WM && yt >= WM && yt < TH - WM;
    pl  = x >= bx_m && x < bx_m + BLK && y >= by_m && y < by_m + BLK;
    rgb = pl ? 12'h0F0 : wl ? 12'hF00 : ext ? 12'hFF0 : ins ? 12'h00F : 12'h000;
    hv[0]  = pix_valid && armed_m;
    hpv[0] = pix_valid;
    hrgb[0] = hv[0] ? rgb : 12'h000;
    hf[0] = frame_no; hx[0] = x; hy[0] = y;
  endtask

  // single compare process
  always @(negedge clk) begin
    if (checking) begin
      n_cmp++;
      if (draw_valid !== hv[2] || {draw_r, draw_g, draw_b} !== hrgb[2] ||
          sync_err !== sync_m || int'(maze_level) != lvl_m ||
          int'(maze_row) != row_m || int'(maze_col) != col_m) begin
        n_bad++;
        $display("FAIL pixel f%0d (%0d,%0d): got dv=%b rgb=%h sync=%b lvl=%0d rc=%0d/%0d, want dv=%b rgb=%h sync=%b lvl=%0d rc=%0d/%0d",
                 hf[2], hx[2], hy[2], draw_valid, {draw_r, draw_g, draw_b}, sync_err,
                 maze_level, maze_row, maze_col, hv[2], hrgb[2], sync_m, lvl_m, row_m, col_m);
      end
      if (lat_pending && draw_valid) begin
        longint lat;
        lat = (longint'($time) + 5 - fs_time) / 10;
        n_cmp++;
        if (lat != 3) begin
          n_bad++;
          $display("FAIL first_draw_latency: got %0d cycles, want 3", lat);
        end
        lat_pending = 0;
      end
      if (hpv[2]) begin
        foreach (probes[i]) begin
          if (probes[i].f == hf[2] && probes[i].x == hx[2] && probes[i].y == hy[2]) begin
            n_cmp++;
            if ({draw_r, draw_g, draw_b} !== probes[i].rgb || draw_valid !== 1'b1) begin
              n_bad++;
              $display("FAIL probe f%0d (%0d,%0d): got dv=%b rgb=%h, want dv=1 rgb=%h",
                       probes[i].f, probes[i].x, probes[i].y, draw_valid,
                       {draw_r, draw_g, draw_b}, probes[i].rgb);
            end
          end
        end
      end
    end
  end

  task automatic step(input logic r_n, input logic pv, input int x, input int y);
    @(negedge clk);
    #1;
    rst = r_n; pix_valid = pv; curr_x = 11'(x); curr_y = 11'(y);
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic run_frame(input int chg_y, input int nl, input int nbx, input int nby,
                           input int jump_y, input int rst_y);
    for (int y = 0; y < RH; y++) begin
      if (y == chg_y) begin
        level_select = 2'(nl); blkpos_x = 11'(nbx); blkpos_y = 11'(nby);
      end
      if (y == rst_y) begin
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
      end
      for (int x = 0; x < RW; x++) begin
        if (!(y == jump_y && x > 10 && x < 20)) step(1'b1, 1'b1, x, y);
      end
      for (int h = 0; h < HBL; h++) step(1'b1, 1'b0, 0, 0);
    end
    for (int v = 0; v < VBL; v++) step(1'b1, 1'b0, 0, 0);
  endtask

  function automatic void add_probe(input int f, input int x, input int y, input logic [11:0] rgb);
    probe_t p;
    p.f = f; p.x = x; p.y = y; p.rgb = rgb;
    probes.push_back(p);
  endfunction

  initial begin
    rst = 1'b0; pix_valid = 1'b0; curr_x = 11'd0; curr_y = 11'd0;
    level_select = 2'd0; blkpos_x = 11'd9; blkpos_y = 11'd9;

    // hand-derived pixels for this geometry (8x8 tiles, margin 2, exit tile (row2,col3))
    add_probe(0,  0,  0, 12'hF00);  // top/left wall of tile (0,0)
    add_probe(0, 14, 10, 12'hF00);  // right wall of tile (1,1)
    add_probe(0, 13, 10, 12'h00F);  // just inside right wall
    add_probe(0,  9,  9, 12'h0F0);  // sprite first pixel
    add_probe(0, 11, 11, 12'h0F0);  // sprite last pixel
    add_probe(0, 12, 11, 12'h00F);  // one past sprite
    add_probe(0, 26, 18, 12'hFF0);  // exit interior, lit
    add_probe(0, 25, 18, 12'h00F);  // exit margin
    add_probe(0, 32,  0, 12'h000);  // right of maze
    add_probe(0,  0, 24, 12'h000);  // below maze
    add_probe(0, 20, 14, 12'h00F);  // level-1 wall position, still level 0
    add_probe(1, 20, 14, 12'hF00);  // level 1 bottom wall
    add_probe(1,  2,  1, 12'h0F0);  // sprite over wall
    add_probe(1,  3,  1, 12'hF00);  // wall beside sprite
    add_probe(1, 26, 18, 12'hFF0);  // exit still lit
    add_probe(2, 26, 18, 12'h00F);  // exit dark
    add_probe(2, 22, 15, 12'hF00);  // level 2 bottom/right wall
    add_probe(2, 21, 12, 12'h00F);
    add_probe(3,  0,  0, 12'h00F);  // level 3 ignores ROM
    add_probe(3, 26, 18, 12'h00F);
    add_probe(4, 26, 18, 12'hFF0);  // exit lit again
    add_probe(6, 26, 18, 12'hFF0);  // blink phase restarts after reset
    add_probe(6,  0,  0, 12'hF00);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0);
    checking = 1;
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 0, 0);

    run_frame(14, 1, 0, 1, -1, -1);       // frame 0: level switch mid-frame
    run_frame(RH - 1, 2, 100, 100, -1, -1);
    run_frame(RH - 1, 3, 100, 100, -1, -1);
    run_frame(RH - 1, 0, 100, 100, -1, -1);
    run_frame(-1, 0, 0, 0, -1, -1);        // frame 4
    run_frame(-1, 0, 0, 0, 3, 10);         // frame 5: x jump, reset at y=10
    run_frame(-1, 0, 0, 0, -1, -1);        // frame 6
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0, 0);

    n_cmp++;
    if (lat_pending) begin
      n_bad++;
      $display("FAIL first_draw_seen: got none, want draw_valid after frame start");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
